// File: rtl/pipe_ctrl_pkg.sv
// Shared types and parameter defaults for the pipeline hazard / DMA sequencing controller.
package pipe_ctrl_pkg;

   // State encodings: ST_RUN=0, ST_DRAIN=1, ST_OWN=2.
   // The ST_ prefix keeps these literals apart from the DRAIN parameter of the top module.
   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_OWN   = 2'd2
   } state_t;

   localparam int REGW_DEF   = 5;
   localparam int DRAIN_DEF  = 3;
   localparam int MAXOWN_DEF = 64;

endpackage

// File: rtl/pipe_hazard_ctrl_loaduse_detect.sv
// Load-use comparator.
// A load in EX whose nonzero destination register feeds either source operand of the instruction in ID.
module loaduse_detect
   import pipe_ctrl_pkg::*;
#(
   parameter int REGW = REGW_DEF
) (
   input  logic [REGW-1:0] id_rs1,
   input  logic [REGW-1:0] id_rs2,
   input  logic [REGW-1:0] ex_rd,
   input  logic            ex_memread,
   output logic            loaduse
);

   // Register x0 is never a real dependency, so a load that targets it cannot stall.
   assign loaduse = ex_memread && (ex_rd != '0) &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stall, branch flush, and DMA bus arbitration.
// PIPE_HAZARD_CTRL_DMA_EN enables the DRAIN/OWN states, the drain and ownership
// counters, holdoff, and dma_gnt. Without it the controller stays in RUN, dma_req
// is ignored, and dma_gnt is tied low.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  ST_RUN   | normal issue; load-use stalls and branch flushes apply
//  ST_DRAIN | bubbles inserted while the pipe empties; cnt counts down
//  ST_OWN   | bus granted to the DMA; own counts cycles of ownership
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int REGW   = REGW_DEF,
   parameter int DRAIN  = DRAIN_DEF,
   parameter int MAXOWN = MAXOWN_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [REGW-1:0] id_rs1,
   input  logic [REGW-1:0] id_rs2,
   input  logic [REGW-1:0] ex_rd,
   input  logic            ex_memread,
   input  logic            branch_taken,
   input  logic            dma_req,
   output logic            pc_en,
   output logic            ifid_en,
   output logic            ifid_flush,
   output logic            idex_en,
   output logic            dma_gnt
);

   logic   loaduse;
   state_t state_q;

   loaduse_detect #(.REGW(REGW)) u_loaduse (
      .id_rs1     (id_rs1),
      .id_rs2     (id_rs2),
      .ex_rd      (ex_rd),
      .ex_memread (ex_memread),
      .loaduse    (loaduse)
   );

`ifdef PIPE_HAZARD_CTRL_DMA_EN
   state_t     state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] own_q, own_d;
   logic       holdoff_q, holdoff_d;
   logic       dma_gnt_q;

   // State and counter registers; the grant is registered from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_RUN;
         cnt_q     <= 4'd0;
         own_q     <= 8'd0;
         holdoff_q <= 1'b0;
         dma_gnt_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         own_q     <= own_d;
         holdoff_q <= holdoff_d;
         dma_gnt_q <= (state_d == ST_OWN);
      end
   end

   // Next-state logic: drain the pipe, grant the bus, and bound how long the DMA keeps it.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      own_d     = own_q;
      holdoff_d = holdoff_q;
      case (state_q)
         ST_RUN: begin
            holdoff_d = 1'b0;
            if (dma_req && !holdoff_q) begin
               state_d = ST_DRAIN;
               cnt_d   = 4'(DRAIN - 1);
            end
         end
         ST_DRAIN: begin
            if (!dma_req) begin
               state_d = ST_RUN;
            end else if (cnt_q == 4'd0) begin
               state_d = ST_OWN;
               own_d   = 8'd0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_OWN: begin
            // The limit is compared before incrementing, so own never wraps at MAXOWN=256.
            if (!dma_req || (own_q == 8'(MAXOWN - 1))) begin
               state_d   = ST_RUN;
               holdoff_d = 1'b1;
            end else begin
               own_d = own_q + 8'd1;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   assign dma_gnt = dma_gnt_q;
`else
   logic dma_unused;

   assign state_q    = ST_RUN;
   assign dma_gnt    = 1'b0;
   assign dma_unused = clk ^ dma_req ^ (DRAIN == 0) ^ (MAXOWN == 0);
`endif

   // Pipeline register enables from the state and the current hazards; reset clears the pipe.
   always_comb begin
      pc_en      = 1'b1;
      ifid_en    = 1'b1;
      ifid_flush = 1'b0;
      idex_en    = 1'b1;
      if (rst) begin
         pc_en      = 1'b0;
         ifid_en    = 1'b0;
         ifid_flush = 1'b1;
         idex_en    = 1'b0;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (branch_taken) begin
                  ifid_flush = 1'b1;
                  idex_en    = 1'b0;
               end else if (loaduse) begin
                  pc_en   = 1'b0;
                  ifid_en = 1'b0;
                  idex_en = 1'b0;
               end
            end
            ST_DRAIN: begin
               // A branch resolving during the drain still redirects the PC and squashes the wrong path.
               pc_en      = branch_taken;
               ifid_en    = 1'b0;
               ifid_flush = branch_taken;
               idex_en    = 1'b0;
            end
            default: begin
               pc_en   = 1'b0;
               ifid_en = 1'b0;
               idex_en = 1'b0;
            end
         endcase
      end
   end

endmodule
